// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers resolved-branch updates in a small FIFO, retires one per cycle
// onto a registered BTB write port, runs the invalidate sweep and owns the global 2-bit counter.
module btb_update_ctrl #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned IDX_W     = 8,
  parameter logic [15:0] EMPTY_TGT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_all,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [15:0]       upd_pc,
  input  logic [15:0]       upd_target,
  input  logic              upd_taken,
  input  logic              upd_is_branch,
  output logic              btb_we,
  output logic [IDX_W-1:0]  btb_index,
  output logic [15-IDX_W:0] btb_wtag,
  output logic [15:0]       btb_wtarget,
  output logic [1:0]        ctr_state,
  output logic              pred_enable,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
    logic        is_branch;
  } rec_t;

  // StSweepLast is the idle cycle after the final sweep write, before prediction is enabled.
  typedef enum logic [1:0] {
    StSweep,
    StSweepLast,
    StRun
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  rec_t              fifo_q [QDEPTH];

  logic              we_q, we_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [15-IDX_W:0] tag_q, tag_d;
  logic [15:0]       tgt_q, tgt_d;
  logic [1:0]        ctr_q, ctr_d;
  logic              pred_q, pred_d;

  logic              in_run;
  logic              fifo_full;
  logic              fifo_empty;
  logic              do_flush;
  logic              do_enq;
  logic              do_deq;
  rec_t              head;
  rec_t              new_rec;

  assign in_run     = (state_q == StRun);
  assign fifo_full  = (count_q == CntW'(QDEPTH));
  assign fifo_empty = (count_q == '0);
  assign do_flush   = in_run && flush_all;
  // A flush drops a same-cycle enqueue even though ready was high.
  assign do_enq     = in_run && upd_valid && !fifo_full && !flush_all;
  assign do_deq     = in_run && !fifo_empty && !flush_all;
  assign head       = fifo_q[rd_ptr_q];

  assign new_rec.pc        = upd_pc;
  assign new_rec.target    = upd_target;
  assign new_rec.taken     = upd_taken;
  assign new_rec.is_branch = upd_is_branch;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    we_d        = 1'b0;
    index_d     = index_q;
    tag_d       = tag_q;
    tgt_d       = tgt_q;
    ctr_d       = ctr_q;

    unique case (state_q)
      StSweep: begin
        we_d        = 1'b1;
        index_d     = sweep_idx_q;
        tag_d       = '0;
        tgt_d       = EMPTY_TGT;
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == '1) begin
          state_d = StSweepLast;
        end
      end
      StSweepLast: begin
        state_d = StRun;
      end
      StRun: begin
        if (do_flush) begin
          state_d     = StSweep;
          sweep_idx_d = '0;
          ctr_d       = 2'b00;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
        end else begin
          if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (head.taken) begin
              we_d    = 1'b1;
              index_d = head.pc[IDX_W-1:0];
              tag_d   = head.pc[15:IDX_W];
              tgt_d   = head.target;
            end
            if (head.is_branch) begin
              if (head.taken && (ctr_q != 2'b11)) begin
                ctr_d = ctr_q + 2'd1;
              end else if (!head.taken && (ctr_q != 2'b00)) begin
                ctr_d = ctr_q - 2'd1;
              end
            end
          end
          if (do_enq) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
          count_d = count_q + CntW'(do_enq) - CntW'(do_deq);
        end
      end
      default: begin
        state_d = StSweep;
      end
    endcase

    pred_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSweep;
      sweep_idx_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      tgt_q       <= '0;
      ctr_q       <= 2'b00;
      pred_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      we_q        <= we_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      ctr_q       <= ctr_d;
      pred_q      <= pred_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_enq && !reset) begin
      fifo_q[wr_ptr_q] <= new_rec;
    end
  end

  assign upd_ready   = in_run && !fifo_full;
  assign busy        = !in_run || !fifo_empty;
  assign btb_we      = we_q;
  assign btb_index   = index_q;
  assign btb_wtag    = tag_q;
  assign btb_wtarget = tgt_q;
  assign ctr_state   = ctr_q;
  assign pred_enable = pred_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the update controller.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush_all, upd_valid, upd_taken, upd_is_branch;
  logic [15:0] upd_pc, upd_target;
  logic        upd_ready, btb_we, pred_enable, busy;
  logic [7:0]  btb_index, btb_wtag;
  logic [15:0] btb_wtarget;
  logic [1:0]  ctr_state;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .flush_all    (flush_all),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_is_branch(upd_is_branch),
    .btb_we       (btb_we),
    .btb_index    (btb_index),
    .btb_wtag     (btb_wtag),
    .btb_wtarget  (btb_wtarget),
    .ctr_state    (ctr_state),
    .pred_enable  (pred_enable),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        taken;
    logic        br;
  } rec_t;

  // Behavioural model: pending records, sweep progress, expected registered outputs.
  rec_t        mq[$];
  bit          m_run;
  int          m_next;
  bit          e_we;
  logic [7:0]  e_idx, e_tag;
  logic [15:0] e_tgt;
  int          e_ctr;
  bit          e_pred;

  task automatic model_step();
    rec_t r;
    bit   rdy;
    if (reset) begin
      mq.delete();
      m_run = 0; m_next = 0; e_we = 0; e_idx = 0; e_tag = 0; e_tgt = 0; e_ctr = 0; e_pred = 0;
    end else if (!m_run) begin
      if (m_next < 256) begin
        e_we = 1; e_idx = 8'(m_next); e_tag = 0; e_tgt = 16'hFFFF;
        m_next++;
      end else begin
        e_we = 0; m_run = 1; e_pred = 1;
      end
    end else begin
      rdy = (mq.size() < 4);
      if (flush_all) begin
        mq.delete();
        e_we = 0; e_ctr = 0; m_run = 0; m_next = 0; e_pred = 0;
      end else begin
        e_we = 0;
        if (mq.size() > 0) begin
          r = mq.pop_front();
          if (r.taken) begin
            e_we = 1; e_idx = r.pc[7:0]; e_tag = r.pc[15:8]; e_tgt = r.tgt;
          end
          if (r.br) begin
            if (r.taken) e_ctr = (e_ctr == 3) ? 3 : e_ctr + 1;
            else e_ctr = (e_ctr == 0) ? 0 : e_ctr - 1;
          end
        end
        if (upd_valid && rdy) begin
          r.pc = upd_pc; r.tgt = upd_target; r.taken = upd_taken; r.br = upd_is_branch;
          mq.push_back(r);
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush_all = 0; upd_valid = 0; upd_taken = 0; upd_is_branch = 0; upd_pc = 0; upd_target = 0;
  endtask

  task automatic drive_rec(input logic [15:0] pc, input logic [15:0] tgt, input logic tk,
                           input logic br);
    upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_branch = br;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    tick();
    tick();
    checks++; if (btb_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", btb_we); end
    checks++; if (btb_index !== 8'h00) begin failures++; $display("FAIL rst_index got=%h exp=00", btb_index); end
    checks++; if (btb_wtag !== 8'h00) begin failures++; $display("FAIL rst_tag got=%h exp=00", btb_wtag); end
    checks++; if (btb_wtarget !== 16'h0000) begin failures++; $display("FAIL rst_tgt got=%h exp=0000", btb_wtarget); end
    checks++; if (ctr_state !== 2'b00) begin failures++; $display("FAIL rst_ctr got=%b exp=00", ctr_state); end
    checks++; if (pred_enable !== 1'b0) begin failures++; $display("FAIL rst_pred got=%b exp=0", pred_enable); end
    checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", upd_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
  endtask

  // Runs a whole sweep from index 0; optionally pulses flush_all when index flush_at is issued.
  task automatic test_sweep(input string name, input int flush_at);
    int writes = 0;
    reset = 0;
    for (int i = 0; i < 257; i++) begin
      flush_all = (flush_at >= 0) && !m_run && (m_next == flush_at);
      tick();
      flush_all = 0;
      checks++;
      if (btb_we !== e_we) begin
        failures++; $display("FAIL %s_we cyc=%0d got=%b exp=%b", name, i, btb_we, e_we);
      end
      checks++;
      if (upd_ready !== 1'b0 && i < 256) begin
        failures++; $display("FAIL %s_ready cyc=%0d got=%b exp=0", name, i, upd_ready);
      end
      checks++;
      if (pred_enable !== e_pred) begin
        failures++; $display("FAIL %s_pred cyc=%0d got=%b exp=%b", name, i, pred_enable, e_pred);
      end
      if (btb_we === 1'b1) begin
        checks++;
        if (btb_index !== 8'(writes) || btb_wtag !== 8'h00 || btb_wtarget !== 16'hFFFF) begin
          failures++;
          $display("FAIL %s_entry cyc=%0d got=%h/%h/%h exp=%h/00/ffff", name, i, btb_index,
                   btb_wtag, btb_wtarget, 8'(writes));
        end
        writes++;
      end
    end
    checks++;
    if (writes != 256) begin failures++; $display("FAIL %s_count got=%0d exp=256", name, writes); end
    checks++;
    if (pred_enable !== 1'b1 || upd_ready !== 1'b1) begin
      failures++; $display("FAIL %s_end got=pred%b/rdy%b exp=pred1/rdy1", name, pred_enable, upd_ready);
    end
  endtask

  task automatic test_single();
    drive_rec(16'h1234, 16'h1240, 1, 1);
    tick();
    drive_idle();
    tick();
    checks++;
    if (btb_we !== 1'b1 || btb_index !== 8'h34 || btb_wtag !== 8'h12 || btb_wtarget !== 16'h1240) begin
      failures++;
      $display("FAIL single_write got=%b/%h/%h/%h exp=1/34/12/1240", btb_we, btb_index, btb_wtag,
               btb_wtarget);
    end
    checks++; if (ctr_state !== 2'b01) begin failures++; $display("FAIL single_ctr got=%b exp=01", ctr_state); end
    tick();
    checks++; if (btb_we !== 1'b0) begin failures++; $display("FAIL single_idle_we got=%b exp=0", btb_we); end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive_rec(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1, 1);
      else drive_idle();
      checks++;
      if (upd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, upd_ready); end
      tick();
      checks++;
      if (btb_we !== e_we || (e_we && (btb_index !== e_idx || btb_wtag !== e_tag ||
                                       btb_wtarget !== e_tgt))) begin
        failures++;
        $display("FAIL b2b_write cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", i, btb_we, btb_index,
                 btb_wtag, btb_wtarget, e_we, e_idx, e_tag, e_tgt);
      end
      if (btb_we === 1'b1) writes++;
    end
    checks++; if (writes != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", writes); end
    checks++; if (ctr_state !== 2'b11) begin failures++; $display("FAIL b2b_ctr got=%b exp=11", ctr_state); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
  endtask

  task automatic test_not_taken();
    drive_rec(16'h5678, 16'h0010, 0, 1);
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nt_busy got=%b exp=1", busy); end
    drive_rec(16'hABCD, 16'h4000, 1, 0);
    tick();
    checks++; if (btb_we !== 1'b0) begin failures++; $display("FAIL nt_we got=%b exp=0", btb_we); end
    checks++; if (ctr_state !== 2'b10) begin failures++; $display("FAIL nt_ctr got=%b exp=10", ctr_state); end
    drive_idle();
    tick();
    checks++;
    if (btb_we !== 1'b1 || btb_index !== 8'hCD || btb_wtag !== 8'hAB || btb_wtarget !== 16'h4000) begin
      failures++;
      $display("FAIL jump_write got=%b/%h/%h/%h exp=1/cd/ab/4000", btb_we, btb_index, btb_wtag,
               btb_wtarget);
    end
    checks++; if (ctr_state !== 2'b10) begin failures++; $display("FAIL jump_ctr got=%b exp=10", ctr_state); end
  endtask

  task automatic test_flush();
    drive_rec(16'h2222, 16'h3333, 1, 1);
    tick();
    drive_rec(16'h4444, 16'h5555, 1, 1);
    flush_all = 1;
    tick();
    drive_idle();
    checks++; if (ctr_state !== 2'b00) begin failures++; $display("FAIL flush_ctr got=%b exp=00", ctr_state); end
    checks++; if (btb_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", btb_we); end
    checks++;
    if (upd_ready !== 1'b0 || pred_enable !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_status got=rdy%b/pred%b/busy%b exp=rdy0/pred0/busy1", upd_ready,
               pred_enable, busy);
    end
    test_sweep("flush_sweep", 100);
    tick();
    checks++; if (btb_we !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", btb_we); end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 50; i++) tick();
    checks++; if (btb_index !== 8'd49) begin failures++; $display("FAIL mid_pre_index got=%h exp=31", btb_index); end
    reset = 1;
    tick();
    checks++;
    if (btb_we !== 1'b0 || btb_index !== 8'h00 || busy !== 1'b1 || upd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_sweep_rst got=%b/%h/%b/%b exp=0/00/1/0", btb_we, btb_index, busy, upd_ready);
    end
    test_sweep("rst_sweep", -1);
    drive_rec(16'h0101, 16'h0202, 1, 1);
    tick();
    drive_rec(16'h0303, 16'h0404, 1, 1);
    tick();
    checks++; if (ctr_state !== 2'b01) begin failures++; $display("FAIL mid_run_ctr got=%b exp=01", ctr_state); end
    drive_rec(16'h0505, 16'h0606, 1, 1);
    reset = 1;
    tick();
    drive_idle();
    checks++;
    if (ctr_state !== 2'b00 || btb_we !== 1'b0 || upd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_rst got=ctr%b/we%b/rdy%b exp=ctr00/we0/rdy0", ctr_state, btb_we, upd_ready);
    end
    test_sweep("rst_run_sweep", -1);
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_run_empty got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      upd_valid     = 1'($urandom_range(0, 1));
      upd_pc        = 16'($urandom_range(0, 65535));
      upd_target    = 16'($urandom_range(0, 65535));
      upd_taken     = 1'($urandom_range(0, 1));
      upd_is_branch = 1'($urandom_range(0, 3) != 0);
      flush_all     = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (btb_we !== e_we || btb_index !== e_idx || btb_wtag !== e_tag || btb_wtarget !== e_tgt) begin
        failures++;
        $display("FAIL rnd_write cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", i, btb_we, btb_index,
                 btb_wtag, btb_wtarget, e_we, e_idx, e_tag, e_tgt);
      end
      checks++;
      if (ctr_state !== 2'(e_ctr)) begin
        failures++; $display("FAIL rnd_ctr cyc=%0d got=%b exp=%0d", i, ctr_state, e_ctr);
      end
      checks++;
      if (upd_ready !== (m_run && mq.size() < 4) || busy !== (!m_run || mq.size() != 0) ||
          pred_enable !== e_pred) begin
        failures++;
        $display("FAIL rnd_status cyc=%0d got=rdy%b/busy%b/pred%b exp=rdy%b/busy%b/pred%b", i,
                 upd_ready, busy, pred_enable, m_run && mq.size() < 4, !m_run || mq.size() != 0,
                 e_pred);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_sweep("init_sweep", -1);
    test_single();
    test_back_to_back();
    test_not_taken();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
